// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension arbiter: extend-type codes,
// field widths and the output-slot state encoding.
package imm_ext_pkg;

  localparam int unsigned IMM_W  = 26;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    EXT_I16 = 2'b00,
    EXT_J21 = 2'b01,
    EXT_J26 = 2'b10,
    EXT_U16 = 2'b11
  } ext_type_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational immediate extender. Type 11 zero-extends imm[15:0] when
// IMM_EXT_ZEXT_EN is defined, otherwise it yields zero.
module imm_ext_unit
  import imm_ext_pkg::*;
(
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        ext_type,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    case (ext_type_e'(ext_type))
      EXT_I16: data = {{16{imm[15]}}, imm[15:0]};
      EXT_J21: data = {{11{imm[20]}}, imm[20:0]};
      EXT_J26: data = {{6{imm[25]}}, imm[25:0]};
`ifdef IMM_EXT_ZEXT_EN
      EXT_U16: data = {16'h0000, imm[15:0]};
`else
      EXT_U16: data = '0;
`endif
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter feeding one shared immediate extender into a single
// registered result slot. Optional macro: IMM_EXT_ZEXT_EN (see imm_ext_unit).
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*IMM_W-1:0] req_imm,
  input  logic [NREQ*2-1:0]     req_type,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  output logic [DATA_W-1:0]     res_data,
  output logic [IDW-1:0]        res_id,
  input  logic                  res_ready
);

  slot_state_e       state, state_next;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    scan_idx;
  logic [IDW-1:0]    gnt_idx;
  logic [NREQ-1:0]   grant;
  logic              found;
  logic              can_grant;
  logic              fire;
  logic [IMM_W-1:0]  imm_sel;
  logic [1:0]        type_sel;
  logic [DATA_W-1:0] ext_data;

  // Reset gates the grant combinationally so req_ready stays low during reset.
  assign can_grant = rst_n && ((state == SLOT_EMPTY) || res_ready);
  assign fire      = |grant;

  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    scan_idx = '0;
    found    = 1'b0;
    if (can_grant) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        scan_idx = IDW'((32'(rr_ptr) + k) % NREQ);
        if (!found && req_valid[scan_idx]) begin
          found           = 1'b1;
          grant[scan_idx] = 1'b1;
          gnt_idx         = scan_idx;
        end
      end
    end
  end

  always_comb begin
    imm_sel  = '0;
    type_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        imm_sel  = req_imm[i*IMM_W +: IMM_W];
        type_sel = req_type[i*2 +: 2];
      end
    end
  end

  imm_ext_unit u_ext (
    .imm      (imm_sel),
    .ext_type (type_sel),
    .data     (ext_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SLOT_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SLOT_EMPTY: if (fire) state_next = SLOT_FULL;
      SLOT_FULL:  if (res_ready && !fire) state_next = SLOT_EMPTY;
      default:    state_next = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    res_valid = (state == SLOT_FULL);
    req_ready = grant;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data <= '0;
      res_id   <= '0;
      rr_ptr   <= '0;
    end else if (fire) begin
      res_data <= ext_data;
      res_id   <= gnt_idx;
      rr_ptr   <= IDW'((32'(gnt_idx) + 1) % NREQ);
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Randomized plus directed bench for imm_ext_arbiter against a behavioural
// round-robin / extension model.
module tb_imm_ext_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned IDW  = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*26-1:0]  req_imm;
  logic [NREQ*2-1:0]   req_type;
  logic [NREQ-1:0]     req_ready;
  logic                res_valid;
  logic [31:0]         res_data;
  logic [IDW-1:0]      res_id;
  logic                res_ready;

  int n_total;
  int n_bad;

  // Model state
  bit          m_full;
  logic [31:0] m_data;
  int          m_id;
  int          m_ptr;

  imm_ext_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_imm   (req_imm),
    .req_type  (req_type),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [25:0] imm, input logic [1:0] t);
    longint v;
    int     bits;
    case (t)
      2'd0: bits = 16;
      2'd1: bits = 21;
      2'd2: bits = 26;
      default: bits = 0;
    endcase
    if (bits == 0) begin
`ifdef IMM_EXT_ZEXT_EN
      return 32'(longint'(imm) % 65536);
`else
      return 32'h0;
`endif
    end
    v = longint'(imm) % (longint'(1) << bits);
    if (v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  function automatic int model_pick();
    int idx;
    if (!rst_n || (m_full && !res_ready)) return -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: check combinational grant, advance model, check registered outputs.
  task automatic cycle();
    int g;
    logic [NREQ-1:0] exp_ready;
    #1;
    g = model_pick();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (!rst_n) begin
      m_full = 1'b0;
      m_data = '0;
      m_id   = 0;
      m_ptr  = 0;
    end else if (g >= 0) begin
      m_full = 1'b1;
      m_data = ext_model(req_imm[g*26 +: 26], req_type[g*2 +: 2]);
      m_id   = g;
      m_ptr  = (g + 1) % NREQ;
    end else if (m_full && res_ready) begin
      m_full = 1'b0;
    end
    #1;
    check("res_valid", 32'(res_valid), 32'(m_full));
    check("res_data", res_data, m_data);
    check("res_id", 32'(res_id), 32'(m_id));
  endtask

  task automatic set_req(input int i, input logic v, input logic [25:0] imm, input logic [1:0] t);
    req_valid[i]      = v;
    req_imm[i*26 +: 26] = imm;
    req_type[i*2 +: 2]  = t;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_u16;
    n_total   = 0;
    n_bad     = 0;
    m_full    = 1'b0;
    m_data    = '0;
    m_id      = 0;
    m_ptr     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_imm   = '0;
    req_type  = '0;
    res_ready = 1'b0;

    do_reset();
    check("reset_valid", 32'(res_valid), 32'h0);
    check("reset_data", res_data, 32'h0);

    // Single request, type 00
    res_ready = 1'b1;
    set_req(0, 1'b1, 26'h000_8001, 2'b00);
    cycle();
    check("single_data", res_data, 32'hFFFF_8001);
    check("single_id", 32'(res_id), 32'h0);
    req_valid = '0;
    cycle();

    // Type coverage through requester 1
    set_req(1, 1'b1, 26'h010_0000, 2'b01);
    cycle();
    check("type01", res_data, 32'hFFF0_0000);
    set_req(1, 1'b1, 26'h1FF_FFFF, 2'b10);
    cycle();
    check("type10", res_data, 32'h01FF_FFFF);
    set_req(1, 1'b1, 26'h000_8001, 2'b11);
    cycle();
`ifdef IMM_EXT_ZEXT_EN
    exp_u16 = 32'h0000_8001;
`else
    exp_u16 = 32'h0;
`endif
    check("type11", res_data, exp_u16);
    check("type11_valid", 32'(res_valid), 32'h1);
    req_valid = '0;
    cycle();

    // Contention between req0 and req1 from a fresh pointer
    do_reset();
    res_ready = 1'b1;
    set_req(0, 1'b1, 26'h000_0011, 2'b00);
    set_req(1, 1'b1, 26'h000_0022, 2'b00);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("contention_id", 32'(res_id), 32'(k % 2));
    end
    req_valid = '0;
    cycle();

    // Backpressure: fill slot, stall 3 cycles, then release
    res_ready = 1'b0;
    req_valid = 3'b011;
    cycle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall_ready", 32'(req_ready), 32'h0);
    end
    res_ready = 1'b1;
    cycle();

    // Reset while FULL
    res_ready = 1'b0;
    req_valid = 3'b111;
    cycle();
    rst_n = 1'b0;
    cycle();
    check("rst_full_valid", 32'(res_valid), 32'h0);
    check("rst_full_data", res_data, 32'h0);
    rst_n = 1'b1;
    res_ready = 1'b1;
    cycle();
    check("post_rst_id", 32'(res_id), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom_range(0, 1)), 26'($urandom), 2'($urandom));
      res_ready = ($urandom_range(0, 9) < 7);
      rst_n     = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
